// File: rtl/brushless_cmt_gen2.sv
// Purpose : six-step BLDC commutation from three hall sensors, with direction control,
//           slew-limited duty ramp, sticky illegal-hall detection and commutation-period measurement.
// Latency : hall edge -> rot after SYNC_STAGES clks plus the next PWM_synch; sel/duty are combinational from state.
// Backpressure: none; PWM_synch paces sampling, and period_vld is a one-clk strobe with no handshake.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   drv_mag_i               unsigned drive magnitude from the PID stage
//   dir_i                   0 = forward, 1 = reverse (swaps FWD/REV on every phase)
//   hallGrn_i/Ylw_i/Blu_i   asynchronous hall sensor inputs
//   brake_n_i               active-low brake (all phases REGEN, fixed brake duty)
//   PWM_synch_i             one-clk pulse at each PWM period boundary
//   clr_fault_i             clears hall_fault_o (only while rot is a legal code)
//   duty_o                  PWM duty to the PWM stage
//   selGrn_o/Ylw_o/Blu_o    phase select: 00 HIGHZ, 01 REVERSE, 10 FORWARD, 11 REGEN
//   hall_fault_o            sticky illegal-hall flag
//   comm_period_o           clks between the last two legal commutations (saturates on stall)
//   period_vld_o            one-clk strobe when comm_period_o updates
module brushless_cmt_gen2 #(
  parameter int DUTY_W      = 11,
  parameter int MAG_W       = 12,
  parameter int SYNC_STAGES = 2,
  parameter int RAMP_STEP   = 8,
  parameter int BRAKE_DUTY  = 1536,
  parameter int PER_W       = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [MAG_W-1:0]  drv_mag_i,
  input  logic              dir_i,
  input  logic              hallGrn_i,
  input  logic              hallYlw_i,
  input  logic              hallBlu_i,
  input  logic              brake_n_i,
  input  logic              PWM_synch_i,
  input  logic              clr_fault_i,
  output logic [DUTY_W-1:0] duty_o,
  output logic [1:0]        selGrn_o,
  output logic [1:0]        selYlw_o,
  output logic [1:0]        selBlu_o,
  output logic              hall_fault_o,
  output logic [PER_W-1:0]  comm_period_o,
  output logic              period_vld_o
);

  localparam int                SHIFT     = MAG_W - DUTY_W + 1;
  localparam logic [DUTY_W-1:0] DUTY_MID  = {1'b1, {(DUTY_W-1){1'b0}}};
  localparam logic [DUTY_W-1:0] STEP      = DUTY_W'(RAMP_STEP);
  localparam logic [DUTY_W-1:0] BRAKE     = DUTY_W'(BRAKE_DUTY);
  localparam logic [PER_W-1:0]  CNT_MAX   = '1;
  localparam logic [PER_W-1:0]  CNT_ONE   = PER_W'(1);
  localparam logic [2:0]        IDX_BAD   = 3'd7;

  localparam logic [1:0] SEL_Z     = 2'b00;
  localparam logic [1:0] SEL_REV   = 2'b01;
  localparam logic [1:0] SEL_FWD   = 2'b10;
  localparam logic [1:0] SEL_REGEN = 2'b11;

  // Position of a hall code in the commutation sequence; IDX_BAD for 000/111.
  function automatic logic [2:0] seq_idx(input logic [2:0] h);
    case (h)
      3'b001:  seq_idx = 3'd0;
      3'b011:  seq_idx = 3'd1;
      3'b010:  seq_idx = 3'd2;
      3'b110:  seq_idx = 3'd3;
      3'b100:  seq_idx = 3'd4;
      3'b101:  seq_idx = 3'd5;
      default: seq_idx = IDX_BAD;
    endcase
  endfunction

  function automatic logic [2:0] idx_inc(input logic [2:0] i);
    idx_inc = (i == 3'd5) ? 3'd0 : i + 3'd1;
  endfunction

  // Forward-direction selects, packed {G, Y, B}.
  function automatic logic [5:0] fwd_table(input logic [2:0] r);
    case (r)
      3'b001:  fwd_table = {SEL_Z,   SEL_REV, SEL_FWD};
      3'b011:  fwd_table = {SEL_REV, SEL_Z,   SEL_FWD};
      3'b010:  fwd_table = {SEL_REV, SEL_FWD, SEL_Z};
      3'b110:  fwd_table = {SEL_Z,   SEL_FWD, SEL_REV};
      3'b100:  fwd_table = {SEL_FWD, SEL_Z,   SEL_REV};
      3'b101:  fwd_table = {SEL_FWD, SEL_REV, SEL_Z};
      default: fwd_table = {SEL_Z,   SEL_Z,   SEL_Z};
    endcase
  endfunction

  // FWD<->REV by bit swap; HIGHZ maps onto itself (the table never yields REGEN).
  function automatic logic [1:0] swap_dir(input logic [1:0] s);
    swap_dir = {s[0], s[1]};
  endfunction

  // State
  logic [SYNC_STAGES-1:0][2:0] sync_q, sync_d;
  logic [2:0]                  rot_q, rot_d;
  logic                        prev_vld_q, prev_vld_d;
  logic                        hall_fault_q, hall_fault_d;
  logic [DUTY_W-1:0]           duty_q, duty_d;
  logic [PER_W-1:0]            cnt_q, cnt_d;
  logic [PER_W-1:0]            period_q, period_d;
  logic                        period_vld_q, period_vld_d;

  // Next-state helpers
  logic [2:0]        samp;
  logic [2:0]        samp_idx, rot_idx;
  logic              samp_legal, rot_legal, samp_adj, samp_fault;
  logic [DUTY_W-1:0] target, diff, ramped;

  // Magnitude LSBs below the duty resolution are intentionally dropped.
  logic unused_mag;
  assign unused_mag = ^drv_mag_i[SHIFT-1:0];

  assign samp       = sync_q[SYNC_STAGES-1];
  assign samp_idx   = seq_idx(samp);
  assign rot_idx    = seq_idx(rot_q);
  assign samp_legal = (samp_idx != IDX_BAD);
  assign rot_legal  = (rot_idx != IDX_BAD);
  assign samp_adj   = (samp_idx == rot_idx) || (samp_idx == idx_inc(rot_idx)) ||
                      (rot_idx == idx_inc(samp_idx));
  // prev_vld_q implies rot_q is legal, so the adjacency test is well defined.
  assign samp_fault = !samp_legal || (prev_vld_q && !samp_adj);

  // Target = mid-scale plus the top DUTY_W-1 magnitude bits; cannot overflow.
  assign target = DUTY_MID + {1'b0, drv_mag_i[MAG_W-1:SHIFT]};

  always_comb begin
    if (target >= duty_q) begin
      diff   = target - duty_q;
      ramped = (diff <= STEP) ? target : duty_q + STEP;
    end else begin
      diff   = duty_q - target;
      ramped = (diff <= STEP) ? target : duty_q - STEP;
    end
  end

  always_comb begin
    sync_d       = {sync_q[SYNC_STAGES-2:0], {hallGrn_i, hallYlw_i, hallBlu_i}};
    rot_d        = rot_q;
    prev_vld_d   = prev_vld_q;
    hall_fault_d = hall_fault_q;
    cnt_d        = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    period_d     = period_q;
    period_vld_d = 1'b0;
    duty_d       = duty_q;

    if (PWM_synch_i) begin
      rot_d = samp;
      // An illegal sample also drops prev_vld: adjacency from an illegal rot is meaningless.
      prev_vld_d = samp_legal;
      if (samp_fault) begin
        hall_fault_d = 1'b1;
      end else if (!prev_vld_q) begin
        cnt_d = CNT_ONE;               // first legal sample: start timing, nothing to report
      end else if (samp != rot_q) begin
        period_d     = cnt_q;
        period_vld_d = 1'b1;
        cnt_d        = CNT_ONE;
      end
    end

    // Clearing restarts adjacency checking; a fault detected in the same clk wins.
    if (clr_fault_i && rot_legal) begin
      prev_vld_d = 1'b0;
      if (!(PWM_synch_i && samp_fault)) begin
        hall_fault_d = 1'b0;
      end
    end

    // Braking or faulted: park the ramp at mid-scale so it restarts from there.
    if (!brake_n_i || hall_fault_q) begin
      duty_d = DUTY_MID;
    end else if (PWM_synch_i) begin
      duty_d = ramped;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q       <= '0;
      rot_q        <= 3'b000;
      prev_vld_q   <= 1'b0;
      hall_fault_q <= 1'b0;
      duty_q       <= DUTY_MID;
      cnt_q        <= '0;
      period_q     <= '0;
      period_vld_q <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      rot_q        <= rot_d;
      prev_vld_q   <= prev_vld_d;
      hall_fault_q <= hall_fault_d;
      duty_q       <= duty_d;
      cnt_q        <= cnt_d;
      period_q     <= period_d;
      period_vld_q <= period_vld_d;
    end
  end

  // Output stage: brake > fault > commutation table.
  logic [5:0] sel_fwd, sel_tbl, sel_all;

  always_comb begin
    sel_fwd = fwd_table(rot_q);
    sel_tbl = dir_i ? {swap_dir(sel_fwd[5:4]), swap_dir(sel_fwd[3:2]), swap_dir(sel_fwd[1:0])}
                    : sel_fwd;
    if (!brake_n_i) begin
      sel_all = {SEL_REGEN, SEL_REGEN, SEL_REGEN};
      duty_o  = BRAKE;
    end else if (hall_fault_q) begin
      sel_all = {SEL_Z, SEL_Z, SEL_Z};
      duty_o  = '0;
    end else begin
      sel_all = sel_tbl;
      duty_o  = duty_q;
    end
  end

  assign {selGrn_o, selYlw_o, selBlu_o} = sel_all;
  assign hall_fault_o  = hall_fault_q;
  assign comm_period_o = period_q;
  assign period_vld_o  = period_vld_q;

endmodule
